// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit holding HI/LO for the MIPS pipeline.
// mult/div results are computed at start and committed to HI/LO when the busy count expires.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdout
);
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  logic        special;
  logic [5:0]  funct;
  logic        is_md;
  logic        is_div;
  logic        is_signed;
  logic        unused_ir;

  assign special   = (ir_e[31:26] == 6'b000000);
  assign funct     = ir_e[5:0];
  assign is_md     = special && (funct[5:2] == 4'b0110);
  assign is_div    = funct[1];
  assign is_signed = !funct[0];
  assign unused_ir = ^ir_e[25:6];

  logic [4:0]  cnt;
  logic [31:0] phi;
  logic [31:0] plo;
  logic        pwr;

  assign busy  = (cnt != 5'd0);
  assign start = is_md && !busy;

  // Products: sign-extended operands give the signed product in the low 64 bits.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{rs_e[31]}}, rs_e} * {{32{rt_e[31]}}, rt_e};
  assign prod_u = {32'd0, rs_e} * {32'd0, rt_e};

  // One unsigned divider; signed division runs on magnitudes and fixes signs afterwards.
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  assign a_mag    = rs_e[31] ? (32'd0 - rs_e) : rs_e;
  assign b_mag    = rt_e[31] ? (32'd0 - rt_e) : rt_e;
  assign div_zero = (rt_e == 32'd0);
  assign num      = is_signed ? a_mag : rs_e;
  assign den      = div_zero ? 32'd1 : (is_signed ? b_mag : rt_e);
  assign quo      = num / den;
  assign rem      = num % den;

  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (!is_div) begin
      {res_hi, res_lo} = is_signed ? prod_s : prod_u;
    end else begin
      res_lo = (is_signed && (rs_e[31] ^ rt_e[31])) ? (32'd0 - quo) : quo;
      res_hi = (is_signed && rs_e[31]) ? (32'd0 - rem) : rem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi  <= 32'd0;
      lo  <= 32'd0;
      phi <= 32'd0;
      plo <= 32'd0;
      cnt <= 5'd0;
      pwr <= 1'b0;
    end else if (start) begin
      phi <= res_hi;
      plo <= res_lo;
      pwr <= !(is_div && div_zero);
      cnt <= is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
    end else if (busy) begin
      cnt <= cnt - 5'd1;
      if (cnt == 5'd1 && pwr) begin
        hi <= phi;
        lo <= plo;
      end
    end else if (special) begin
      if (funct == F_MTHI) hi <= rs_e;
      if (funct == F_MTLO) lo <= rs_e;
    end
  end

  always_comb begin
    mdout = 32'd0;
    if (special && funct == F_MFHI) mdout = hi;
    if (special && funct == F_MFLO) mdout = lo;
  end
endmodule

// File: tb/tb_mdu_e.sv
// Bench for mdu_e: directed cases plus random instruction stream, scoreboard-checked.
module tb_mdu_e;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir_e = 32'd0;
  logic [31:0] rs_e = 32'd0;
  logic [31:0] rt_e = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdout;

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .ir_e(ir_e), .rs_e(rs_e), .rt_e(rt_e),
    .start(start), .busy(busy), .hi(hi), .lo(lo), .mdout(mdout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_left = 0;
  int          run_len = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ins(logic [5:0] f);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {6'b000000, mid, f};
  endfunction

  // Monitor: an operation's result is presented when busy drops.
  always @(negedge clk) begin
    exp_t e;
    if (reset) run_len = 0;
    else if (busy) run_len++;
    else if (run_len > 0) begin
      if (sb.size() == 0) chk("sb_pop_nonempty", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("busy_len", 32'(run_len), 32'(e.n));
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
      end
      run_len = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (m_left > 0) m_left--;
  endtask

  task automatic wait_idle();
    while (m_left > 0) cyc();
  endtask

  // Reference model: architectural effect of one instruction word.
  task automatic model_issue(logic [31:0] ir, logic [31:0] a, logic [31:0] b);
    logic [5:0]           f;
    bit                   sp;
    longint               sa, sbv, sp64, sq, sr;
    longint unsigned      ua, ub, up;
    exp_t                 e;
    f  = ir[5:0];
    sp = (ir[31:26] == 6'd0);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    if (sp && f inside {6'h18, 6'h19, 6'h1a, 6'h1b} && m_left == 0) begin
      e.hi = m_hi;
      e.lo = m_lo;
      e.n  = (f == 6'h18 || f == 6'h19) ? MC : DC;
      if (f == 6'h18) begin
        sp64 = sa * sbv;
        e.hi = sp64[63:32];
        e.lo = sp64[31:0];
      end else if (f == 6'h19) begin
        up = ua * ub;
        e.hi = up[63:32];
        e.lo = up[31:0];
      end else if (b != 32'd0 && f == 6'h1a) begin
        sq = sa / sbv;
        sr = sa % sbv;
        e.lo = sq[31:0];
        e.hi = sr[31:0];
      end else if (b != 32'd0) begin
        up = ua / ub;
        e.lo = up[31:0];
        up = ua % ub;
        e.hi = up[31:0];
      end
      sb.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
      m_left = e.n + 1;
    end else if (sp && m_left == 0 && f == 6'h11) m_hi = a;
    else if (sp && m_left == 0 && f == 6'h13) m_lo = a;
  endtask

  task automatic do_instr(logic [31:0] ir, logic [31:0] a, logic [31:0] b);
    bit sp, md;
    sp = (ir[31:26] == 6'd0);
    md = sp && (ir[5:0] inside {6'h18, 6'h19, 6'h1a, 6'h1b});
    ir_e = ir;
    rs_e = a;
    rt_e = b;
    #1;
    chk("start", 32'(start), 32'(md && m_left == 0));
    if (sp && ir[5:0] == 6'h10) begin
      if (m_left == 0) chk("mdout_mfhi", mdout, m_hi);
    end else if (sp && ir[5:0] == 6'h12) begin
      if (m_left == 0) chk("mdout_mflo", mdout, m_lo);
    end else chk("mdout_zero", mdout, 32'd0);
    model_issue(ir, a, b);
    cyc();
    ir_e = 32'd0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  fl[11];
    logic [31:0] ir;
    int          k;
    fl = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h11, 6'h12, 6'h13, 6'h21, 6'h2a, 6'h00};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_mdout", mdout, 32'd0);

    do_instr(ins(6'h19), 32'hFFFF_FFFF, 32'd2);
    for (int c = 1; c <= MC; c++) begin
      chk("multu_busy", 32'(busy), 32'd1);
      cyc();
    end
    chk("multu_idle", 32'(busy), 32'd0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    do_instr(ins(6'h18), 32'hFFFF_FFFD, 32'd7);
    wait_idle();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    do_instr(ins(6'h1a), 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    do_instr(ins(6'h1b), 32'hFFFF_FFFF, 32'h10);
    wait_idle();
    chk("divu_hi", hi, 32'h0000_000F);
    chk("divu_lo", lo, 32'h0FFF_FFFF);

    do_instr(ins(6'h1a), 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("divovf_hi", hi, 32'd0);
    chk("divovf_lo", lo, 32'h8000_0000);

    do_instr(ins(6'h11), 32'h11, 32'd0);
    do_instr(ins(6'h13), 32'h22, 32'd0);
    do_instr(ins(6'h1b), 32'h1234, 32'd0);
    wait_idle();
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    do_instr(ins(6'h11), 32'hA5A5_0001, 32'd0);
    do_instr(ins(6'h13), 32'h5A5A_0002, 32'd0);
    ir_e = ins(6'h10);
    #1;
    chk("mfhi_const", mdout, 32'hA5A5_0001);
    ir_e = ins(6'h12);
    #1;
    chk("mflo_const", mdout, 32'h5A5A_0002);
    ir_e = ins(6'h21);
    #1;
    chk("addu_mdout", mdout, 32'd0);
    ir_e = 32'd0;

    do_instr(ins(6'h18), 32'd3, 32'd5);
    cyc();
    do_instr(ins(6'h18), 32'd100, 32'd100);
    do_instr(ins(6'h13), 32'hDEAD, 32'd0);
    wait_idle();
    chk("ovl_hi", hi, 32'd0);
    chk("ovl_lo", lo, 32'd15);

    do_instr(ins(6'h11), 32'h77, 32'd0);
    do_instr(ins(6'h1a), 32'd1000, 32'd7);
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    sb.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    m_left = 0;
    cyc();
    reset = 1'b0;
    repeat (DC + 2) cyc();
    chk("arst_after_hi", hi, 32'd0);
    chk("arst_after_lo", lo, 32'd0);

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 11);
      if (k == 11) ir = {6'b100011, 20'($urandom), 6'h18};
      else ir = ins(fl[k]);
      if ($urandom_range(0, 3) != 0) wait_idle();
      do_instr(ir, rnd_val(), rnd_val());
    end
    wait_idle();
    repeat (2) cyc();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_e.md
# mdu_e

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It decodes `ir_e`, takes the forwarded rs/rt operands produced by the E-stage bypass muxes, and runs mult/multu/div/divu as multi-cycle operations into the HI/LO registers. It serves mthi/mtlo/mfhi/mflo, and drives `start`/`busy` to the hazard unit so that D-stage multiply/divide instructions stall while an operation is in flight. `mdout` is carried down the pipeline to the writeback data mux.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1-31.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1-31.

- `clk`  in  1  single pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ir_e`  in  32  E-stage instruction word.
- `rs_e`  in  32  forwarded rs value (bypass mux output).
- `rt_e`  in  32  forwarded rt value (bypass mux output).
- `start`  out  1  combinational; high when `ir_e` is mult/multu/div/divu and `busy`=0.
- `busy`  out  1  registered; high while an operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `mdout`  out  32  combinational; `hi` for mfhi, `lo` for mflo, 0 otherwise.

## Operation
- Decode requires opcode 000000. Funct codes: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. All other words are no-ops.
- State: `hi`, `lo`, 5-bit counter `cnt`, pending result registers `phi`/`plo`. `busy` = (`cnt` != 0).
- Reset values: `hi`=`lo`=`phi`=`plo`=0, `cnt`=0, `busy`=0, `start`=0.
- Start edge (`start`=1):
  - The full result is computed from `rs_e`/`rt_e` into `phi`/`plo`.
  - `cnt` loads `MULT_CYCLES` or `DIV_CYCLES`.
- Busy edges: `cnt` decrements each edge. On the edge where `cnt`==1, `hi`<=`phi`, `lo`<=`plo`, and `cnt`<=0.
- mult: {hi,lo} = signed 64-bit product. multu: {hi,lo} = unsigned product.
- div: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (div or divu with rt=0):
  - The full busy period still runs.
  - `hi`/`lo` are left unchanged at completion (pending write suppressed).
- mthi/mtlo with `busy`=0: `hi` (resp. `lo`) <= `rs_e` on the edge.
- mthi/mtlo with `busy`=1: ignored. The hazard unit must prevent this case; the block defines it anyway.
- A mult/multu/div/divu in `ir_e` while `busy`=1: `start`=0, so it is ignored. The hazard unit stalls it in D, and it never reaches E while busy.
- mfhi/mflo: `mdout` is the current register value. The hazard unit stalls them while `start|busy`, so they never read a stale value.
- Reset asserted mid-operation: the operation aborts, all state returns to reset values at once, and no result is written.

## Timing
- Cycle 0: mult in E, `start`=1.
- Cycles 1..N (N = `MULT_CYCLES` or `DIV_CYCLES`): `busy`=1.
- Edge at end of cycle N: `hi`/`lo` update. From cycle N+1, `busy`=0 and the new values are visible.
- Back-to-back: a second md instruction may start in cycle N+1. Effective throughput is one operation per N+1 cycles.
- mthi/mtlo: value visible on `hi`/`lo` the cycle after the instruction is in E. The same cycle gives zero latency to a following mfhi.
- `start` and `mdout` are purely combinational from `ir_e`, `busy`, `hi`, and `lo`. There is no path from `rs_e`/`rt_e` to `start`.

## Test plan
- Reset, then multu rs=0xFFFFFFFF, rt=2:
  - `start`=1 in cycle 0.
  - `busy`=1 in cycles 1-5.
  - Cycle 6: `hi`=0x00000001, `lo`=0xFFFFFFFE, `busy`=0.
- mult rs=0xFFFFFFFD (-3), rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB after 5 busy cycles.
- div rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
- divu with rs=0xFFFFFFFF, rt=0x10 → lo=0x0FFFFFFF, hi=0xF.
- div with rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero:
  - Preload mthi 0x11, mtlo 0x22.
  - Issue divu rt=0 → `busy` for 10 cycles, then hi=0x11, lo=0x22.
- Preload hi/lo, then:
  - mfhi → `mdout`=hi.
  - mflo → `mdout`=lo.
  - addu → `mdout`=0.
- Start div, assert `reset` in cycle 4 → `busy`, `hi`, `lo` = 0 immediately with no clock edge; no write occurs afterwards.
- mult in E at cycle 2 of an in-flight mult (`busy`=1) → `start`=0, and the original result completes unchanged.
